fifo_rr_arbiter: RTL and testbench
==================================

FIFO_RR_ARBITER -- requirements
Module: fifo_rr_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 10, word width of every FIFO.
REQ-002 Parameter NUM_PORTS, fixed 4, number of input FIFOs served.
REQ-003 clk  input  1  single clock; all logic samples on posedge clk.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 fifo_empty  input  4  empty flag of input FIFO i (bit i).
REQ-006 fifo_data  input  4*DATA_WIDTH  FIFO_data_out of input FIFO i in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 out_almost_full  input  1  output FIFO can accept at most one more word.
REQ-008 out_full  input  1  output FIFO full.
REQ-009 pop  output  4  one-hot pop strobe to input FIFO i.
REQ-010 push  output  1  push strobe to output FIFO.
REQ-011 data_out  output  DATA_WIDTH  word presented to output FIFO with push.
REQ-012 grant_id  output  2  index of the port popped in the previous cycle.
REQ-013 state  output  2  current FSM state encoding.
REQ-014 idle  output  1  high when state is IDLE.
REQ-015 error  output  1  sticky overflow flag.

Function
REQ-016 FSM states: RESET=0, IDLE=1, ACTIVE=2, ERROR=3.
REQ-017 Transitions: RESET->IDLE on the first cycle with reset high; IDLE->ACTIVE when a pop is issued; ACTIVE->IDLE when no pop is issued and no word is in flight; any state except RESET->ERROR when push would be asserted while out_full is high; ERROR is left only by reset.
REQ-018 Pop condition: state is IDLE or ACTIVE, at least one fifo_empty bit is low, and out_almost_full is low.
REQ-019 pop is combinational from registered state and current inputs, is one-hot or zero, and never selects a port whose fifo_empty is high.
REQ-020 Round-robin arbitration: the search starts at (last_grant+1) mod 4 and selects the first non-empty port; last_grant updates only when a pop is issued; last_grant reset value is 3, so port 0 wins first.
REQ-021 Latency: pop issued in cycle N produces push=1 in cycle N+1, with data_out equal to the popped FIFO's data and grant_id equal to the popped index.
REQ-022 Back-to-back pops are allowed, giving one push per cycle sustained throughput.
REQ-023 A word popped in cycle N is always pushed in cycle N+1, even if out_almost_full rises in cycle N+1.
REQ-024 Overflow: if push is due while out_full=1, push is suppressed, the word is dropped, error=1 and state=ERROR; in ERROR, pop=0 and push=0.
REQ-025 When no push is due, data_out holds its last value.

Reset
REQ-026 While reset=0 at posedge: state=RESET, pop=0, push=0, data_out=0, grant_id=0, last_grant=3, error=0, idle=0, and the in-flight word is discarded.
REQ-027 Reset asserted mid-transfer cancels the pending push in the next cycle.

Structure
REQ-028 A shared package holds the state encodings, DATA_WIDTH and NUM_PORTS defaults.
REQ-029 One sub-module, rr_priority_enc, is combinational: inputs are the 4-bit request and 2-bit last_grant; outputs are the one-hot grant and the 2-bit index.
REQ-030 The FSM, last_grant, the in-flight valid/index/data registers and the error flag reside in fifo_rr_arbiter.

Verification
REQ-031 Reset held 2 cycles with all FIFOs non-empty -> pop=0 and push=0 throughout; after release, state=IDLE, then port 0 is popped.
REQ-032 All 4 FIFOs non-empty, out_almost_full=0 -> pop sequence 0001,0010,0100,1000,0001; push is high every cycle from the second pop onward; grant_id follows 0,1,2,3.
REQ-033 Only port 2 non-empty holding 0x090..0x093 -> four consecutive pops of port 2; data_out=0x090..0x093 one cycle later each; state returns to IDLE after the last push.
REQ-034 out_almost_full rises during streaming -> pop drops the same cycle, the single in-flight word is still pushed, and streaming resumes when the flag falls.
REQ-035 out_full=1 while a word is in flight -> push stays 0, error=1, state=ERROR, no further pops; reset clears the condition.
REQ-036 Port 1 popped last, then only ports 0 and 1 non-empty -> port 0 is granted next (wrap-around fairness).

Source files
------------

// File: rtl/fifo_rr_arbiter_pkg.sv
// fifo_rr_arbiter_pkg: shared sizes and FSM encodings for the round-robin FIFO arbiter
package fifo_rr_arbiter_pkg;
  localparam int DATA_WIDTH_DEF = 10;
  localparam int NUM_PORTS = 4;
  localparam logic [1:0] ST_RESET = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;
  localparam logic [1:0] ST_ERROR = 2'd3;
endpackage

// File: rtl/fifo_rr_arbiter_if.sv
// fifo_rr_arbiter_if: input-FIFO, output-FIFO and status signals of the arbiter
interface fifo_rr_arbiter_if
  import fifo_rr_arbiter_pkg::*;
#(parameter int DATA_WIDTH = DATA_WIDTH_DEF) ();
  logic [NUM_PORTS-1:0] fifo_empty;
  logic [NUM_PORTS*DATA_WIDTH-1:0] fifo_data;
  logic out_almost_full;
  logic out_full;
  logic [NUM_PORTS-1:0] pop;
  logic push;
  logic [DATA_WIDTH-1:0] data_out;
  logic [1:0] grant_id;
  logic [1:0] state;
  logic idle;
  logic error;
  modport master (
    input fifo_empty, fifo_data, out_almost_full, out_full,
    output pop, push, data_out, grant_id, state, idle, error
  );
  modport slave (
    output fifo_empty, fifo_data, out_almost_full, out_full,
    input pop, push, data_out, grant_id, state, idle, error
  );
endinterface

// File: rtl/fifo_rr_arbiter_rr_priority_enc.sv
// rr_priority_enc: picks the first requester after last_grant, wrapping around
module rr_priority_enc
  import fifo_rr_arbiter_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic [1:0]           last_grant,
  output logic [NUM_PORTS-1:0] grant,
  output logic [1:0]           idx
);
  logic [1:0] p;
  logic hit;
  // scan ports last_grant+1 .. last_grant+4 (mod 4), first hit wins
  always_comb begin
    grant = '0;
    idx = '0;
    hit = 1'b0;
    p = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      p = last_grant + 2'(k);
      if (!hit && req[p]) begin
        grant[p] = 1'b1;
        idx = p;
        hit = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: round-robin drain of four input FIFOs into one output FIFO
module fifo_rr_arbiter
  import fifo_rr_arbiter_pkg::*;
#(parameter int DATA_WIDTH = DATA_WIDTH_DEF)
(
  input logic clk,
  input logic reset,
  fifo_rr_arbiter_if.master bus
);
  logic [1:0] state_q, state_d, last_grant, idx, grant_id_q;
  logic [NUM_PORTS-1:0] req, grant;
  logic [DATA_WIDTH-1:0] data_q;
  logic inflight, can_pop, push, overflow, error_q;
  assign req = ~bus.fifo_empty;
  rr_priority_enc u_enc (.req(req), .last_grant(last_grant), .grant(grant), .idx(idx));
  assign can_pop = reset && (state_q == ST_IDLE || state_q == ST_ACTIVE) && |req && !bus.out_almost_full;
  assign push = reset && inflight && state_q != ST_ERROR && !bus.out_full;
  assign overflow = reset && inflight && state_q != ST_RESET && state_q != ST_ERROR && bus.out_full;
  // next state: overflow dominates, ACTIVE falls back to IDLE once nothing is popped or in flight
  always_comb begin
    state_d = state_q == ST_RESET ? ST_IDLE :
              overflow ? ST_ERROR :
              state_q == ST_IDLE && can_pop ? ST_ACTIVE :
              state_q == ST_ACTIVE && !can_pop && !inflight ? ST_IDLE : state_q;
  end
  // state, round-robin pointer, one-deep in-flight word and sticky error
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_RESET;
      last_grant <= 2'd3;
      inflight <= 1'b0;
      data_q <= '0;
      grant_id_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      inflight <= can_pop;
      if (can_pop) begin
        last_grant <= idx;
        grant_id_q <= idx;
        data_q <= bus.fifo_data[idx*DATA_WIDTH +: DATA_WIDTH];
      end
      if (overflow) error_q <= 1'b1;
    end
  end
  assign bus.pop = can_pop ? grant : '0;
  assign bus.push = push;
  assign bus.data_out = data_q;
  assign bus.grant_id = grant_id_q;
  assign bus.state = state_q;
  assign bus.idle = state_q == ST_IDLE;
  assign bus.error = error_q;
endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb_fifo_rr_arbiter: directed stimulus with a push scoreboard for fifo_rr_arbiter
module tb_fifo_rr_arbiter;
  import fifo_rr_arbiter_pkg::*;
  typedef struct {
    logic [9:0] data;
    logic [1:0] gid;
    int due;
  } exp_t;
  logic clk = 1'b0;
  logic reset;
  logic [9:0] dat [4];
  exp_t sb [$];
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  fifo_rr_arbiter_if #(.DATA_WIDTH(10)) bus ();
  fifo_rr_arbiter #(.DATA_WIDTH(10)) dut (.clk(clk), .reset(reset), .bus(bus));
  assign bus.fifo_data = {dat[3], dat[2], dat[1], dat[0]};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask
  function automatic logic [1:0] oh2idx(input logic [3:0] v);
    oh2idx = 2'd0;
    for (int i = 0; i < 4; i++) if (v[i]) oh2idx = 2'(i);
  endfunction
  // check pop/state/push mid-cycle; queue the word a pop must deliver next cycle
  task automatic cyc_chk(input logic [3:0] exp_pop, input int exp_st, input bit keep, input int exp_push);
    @(negedge clk);
    #2;
    chk("pop", bus.pop, exp_pop);
    if (exp_st >= 0) chk("state", bus.state, exp_st);
    if (exp_push >= 0) chk("push", bus.push, exp_push);
    if (keep && exp_pop != 4'd0) sb.push_back('{data: dat[oh2idx(exp_pop)], gid: oh2idx(exp_pop), due: cyc + 1});
    @(posedge clk);
    #1;
  endtask
  // monitor: every push must match the oldest queued word in its due cycle
  always @(negedge clk) begin
    if (bus.push === 1'b1) begin
      if (sb.size() == 0) chk("push_unexpected", bus.push, 1'b0);
      else begin
        chk("data_out", bus.data_out, sb[0].data);
        chk("grant_id", bus.grant_id, sb[0].gid);
        chk("push_cycle", cyc, sb[0].due);
        void'(sb.pop_front());
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      chk("push_missing", bus.push, 1'b1);
      void'(sb.pop_front());
    end
  end
  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
  initial begin
    reset = 1'b0;
    bus.fifo_empty = 4'h0;
    bus.out_almost_full = 1'b0;
    bus.out_full = 1'b0;
    dat[0] = 10'h0A0;
    dat[1] = 10'h1B1;
    dat[2] = 10'h2C2;
    dat[3] = 10'h3D3;
    cyc_chk(4'b0000, -1, 1, 0);
    cyc_chk(4'b0000, ST_RESET, 1, 0);
    chk("reset_data_out", bus.data_out, 10'h000);
    chk("reset_error", bus.error, 1'b0);
    chk("reset_idle", bus.idle, 1'b0);
    reset = 1'b1;
    cyc_chk(4'b0000, ST_RESET, 1, 0);
    cyc_chk(4'b0001, ST_IDLE, 1, 0);
    cyc_chk(4'b0010, ST_ACTIVE, 1, 1);
    cyc_chk(4'b0100, ST_ACTIVE, 1, 1);
    cyc_chk(4'b1000, ST_ACTIVE, 1, 1);
    cyc_chk(4'b0001, ST_ACTIVE, 1, 1);
    bus.fifo_empty = 4'hF;
    cyc_chk(4'b0000, ST_ACTIVE, 1, 1);
    cyc_chk(4'b0000, -1, 1, 0);
    cyc_chk(4'b0000, ST_IDLE, 1, 0);
    chk("idle", bus.idle, 1'b1);
    bus.fifo_empty = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      dat[2] = 10'h090 + 10'(k);
      cyc_chk(4'b0100, k == 0 ? ST_IDLE : ST_ACTIVE, 1, k == 0 ? 0 : 1);
    end
    bus.fifo_empty = 4'hF;
    cyc_chk(4'b0000, ST_ACTIVE, 1, 1);
    cyc_chk(4'b0000, -1, 1, 0);
    cyc_chk(4'b0000, ST_IDLE, 1, 0);
    bus.fifo_empty = 4'b1101;
    cyc_chk(4'b0010, ST_IDLE, 1, 0);
    bus.fifo_empty = 4'b1100;
    cyc_chk(4'b0001, ST_ACTIVE, 1, 1);
    cyc_chk(4'b0010, ST_ACTIVE, 1, 1);
    bus.fifo_empty = 4'hF;
    cyc_chk(4'b0000, ST_ACTIVE, 1, 1);
    cyc_chk(4'b0000, -1, 1, 0);
    cyc_chk(4'b0000, ST_IDLE, 1, 0);
    bus.fifo_empty = 4'h0;
    cyc_chk(4'b0100, ST_IDLE, 1, 0);
    cyc_chk(4'b1000, ST_ACTIVE, 1, 1);
    bus.out_almost_full = 1'b1;
    cyc_chk(4'b0000, ST_ACTIVE, 1, 1);
    cyc_chk(4'b0000, -1, 1, 0);
    bus.out_almost_full = 1'b0;
    cyc_chk(4'b0001, ST_IDLE, 1, 0);
    cyc_chk(4'b0010, ST_ACTIVE, 0, 1);
    bus.out_almost_full = 1'b1;
    bus.out_full = 1'b1;
    cyc_chk(4'b0000, ST_ACTIVE, 1, 0);
    bus.out_almost_full = 1'b0;
    bus.out_full = 1'b0;
    cyc_chk(4'b0000, ST_ERROR, 1, 0);
    chk("error", bus.error, 1'b1);
    chk("err_idle", bus.idle, 1'b0);
    cyc_chk(4'b0000, ST_ERROR, 1, 0);
    reset = 1'b0;
    cyc_chk(4'b0000, ST_ERROR, 1, 0);
    cyc_chk(4'b0000, ST_RESET, 1, 0);
    chk("error_cleared", bus.error, 1'b0);
    chk("reset_grant_id", bus.grant_id, 2'd0);
    reset = 1'b1;
    cyc_chk(4'b0000, ST_RESET, 1, 0);
    cyc_chk(4'b0001, ST_IDLE, 1, 0);
    cyc_chk(4'b0010, ST_ACTIVE, 0, 1);
    reset = 1'b0;
    cyc_chk(4'b0000, ST_ACTIVE, 1, 0);
    cyc_chk(4'b0000, ST_RESET, 1, 0);
    reset = 1'b1;
    cyc_chk(4'b0000, ST_RESET, 1, 0);
    cyc_chk(4'b0001, ST_IDLE, 1, 0);
    bus.fifo_empty = 4'hF;
    cyc_chk(4'b0000, ST_ACTIVE, 1, 1);
    cyc_chk(4'b0000, -1, 1, 0);
    cyc_chk(4'b0000, ST_IDLE, 1, 0);
    chk("data_hold", bus.data_out, 10'h0A0);
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
